rpn_stack_ctrl: RTL
===================

Name: rpn_stack_ctrl

Overview:
Command sequencer for the calculator datapath. It is the initiator side of the stack push/pop/replace interface. It accepts one RPN command at a time, checks stack depth, and issues the single-cycle stack strobes. It waits on the stack's valid flag between strobes, performs the arithmetic on top-of-stack operands, and reports result/error. It sits between the key/UART command decoder and the stack block.

Parameters:
DEPTH, 512, stack capacity; PUSH/DUP refused when st_size == DEPTH
W, 32, data width of numbers and stack entries

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command this cycle
cmd_op  in  3  0=PUSH 1=POP 2=ADD 3=SUB 4=MUL 5=NEG 6=DUP 7=SWAP
cmd_num  in  W  literal for PUSH
done  out  1  one-cycle pulse: command finished
err  out  1  valid with done: command rejected, stack untouched
result  out  W  top of stack after command, valid with done
st_push  out  1  stack push strobe
st_pop  out  1  stack pop strobe
st_replace  out  1  stack replace strobe
st_data  out  W  stack write data
st_size  in  10  current stack depth
st_top  in  W  current top of stack (0 when empty)
st_vld  in  1  stack idle and ready to accept a strobe

Behaviour:
- Reset (any cycle, asynchronous): state=IDLE; st_push/st_pop/st_replace=0, st_data=0, done=0, err=0, result=0, internal A/B regs=0. Any in-flight sequence is abandoned. Stack contents are not this block's concern.
- cmd_ready = (state==IDLE) & st_vld & ~done. A command is accepted on an edge with cmd_valid & cmd_ready. cmd_op and cmd_num are latched at acceptance.
- All st_* strobes are registered. Each strobe is high for exactly one cycle, and at most one strobe is high per cycle.
- Stack wait rule: after every strobe, enter SETTLE for 1 cycle (ignore st_vld), then WAITV until st_vld=1. Then sample st_top/st_size.
- States: IDLE, CHECK, POP1, SETTLE, WAITV, OPER, WR, WR2, DONE.
- On acceptance: A<=st_top. The depth check happens in the acceptance cycle using st_size:
  - PUSH, DUP: need st_size < DEPTH.
  - POP, NEG: need st_size >= 1.
  - ADD, SUB, MUL, SWAP: need st_size >= 2.
  - Check fails -> DONE with err=1, result=st_top, no strobe issued.
- PUSH: st_push with st_data=cmd_num -> wait -> DONE.
- POP: st_pop -> wait -> DONE.
- DUP: st_push with st_data=A.
- NEG: st_replace with st_data=0-A.
- ADD/SUB/MUL: st_pop -> wait -> B<=st_top -> st_replace with st_data = B+A, B-A, or low W bits of B*A respectively -> wait -> DONE.
- SWAP: st_pop -> wait -> B<=st_top -> st_replace(A) -> wait -> st_push(B) -> wait -> DONE.
- Arithmetic is modulo 2^W; no overflow flag.
- DONE: done=1 for one cycle, result=st_top, err as determined. Return to IDLE.
- Cycle latency (stack accepting each strobe at once, st_vld low exactly 1 cycle after strobe), counted from acceptance cycle t:
  - PUSH/NEG/DUP: done at t+4.
  - ADD/SUB/MUL: done at t+7.
  - SWAP: done at t+10.
  - depth error: done at t+1.
- POP with st_size==1: the stack may keep st_vld high throughout. The SETTLE cycle guarantees st_top=0 is sampled after the update. done at t+4, result=0.
- Commands arriving while busy are not accepted: cmd_ready stays 0 and cmd_valid is held by the source.
- st_vld low in IDLE: cmd_ready=0, no acceptance.

Test Plan:
- Reset low mid-ADD (during WAITV) -> all strobes 0 immediately, IDLE after release, cmd_ready=1 with st_vld=1, no done pulse.
- PUSH 5, PUSH 7, SUB -> final done result=0xFFFFFFFE (5-7), err=0, st_size=1, exactly one st_pop and one st_replace seen for SUB.
- Empty stack: POP, ADD, NEG each -> done at t+1 with err=1, result=0, no strobe asserted.
- PUSH 3, PUSH 9, SWAP -> result=3, st_size=2; POP -> result=9; then MUL on depth 1 -> err=1.
- Fill to 512 with PUSH, then PUSH and DUP -> err=1, no st_push; MUL of 0x10000 x 0x10000 -> result=0.
- cmd_valid held during busy ADD; also DUP of 0x80000000 -> command taken only when cmd_ready returns; NEG of 0x80000000 -> result 0x80000000.

Source files
------------

// File: rtl/rpn_stack_ctrl_if.sv
// Command and stack-strobe bundle for the RPN sequencer.
// master = the sequencer; slave = its environment (command decoder plus stack block).
interface rpn_stack_ctrl_if #(
    parameter int W = 32
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_num;
    logic         done;
    logic         err;
    logic [W-1:0] result;

    logic         st_push;
    logic         st_pop;
    logic         st_replace;
    logic [W-1:0] st_data;
    logic [9:0]   st_size;
    logic [W-1:0] st_top;
    logic         st_vld;

    modport master (
        input  cmd_valid, cmd_op, cmd_num, st_size, st_top, st_vld,
        output cmd_ready, done, err, result, st_push, st_pop, st_replace, st_data
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_num, st_size, st_top, st_vld,
        input  cmd_ready, done, err, result, st_push, st_pop, st_replace, st_data
    );
endinterface

// File: rtl/rpn_stack_ctrl.sv
// RPN command sequencer: depth-checks one command, drives single-cycle stack strobes,
// waits for the stack between strobes and reports result/error.
module rpn_stack_ctrl #(
    parameter int DEPTH = 512,
    parameter int W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    rpn_stack_ctrl_if.master     bus
);
    typedef enum logic [3:0] {
        IDLE, CHECK, POP1, SETTLE, WAITV, OPER, WR, WR2, DONE
    } state_t;

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_NEG  = 3'd5;
    localparam logic [2:0] OP_DUP  = 3'd6;
    localparam logic [2:0] OP_SWAP = 3'd7;
    localparam logic [9:0] DEPTH_L = 10'(DEPTH);

    // after_reg names the step to take once the stack reports valid again.
    // CHECK and POP1 are resolved on the acceptance edge, so the first strobe
    // leaves without an extra cycle and those encodings are never occupied.
    state_t       state_reg, state_next;
    state_t       after_reg, after_next;
    logic [2:0]   op_reg, op_next;
    logic [W-1:0] a_reg, a_next;
    logic [W-1:0] b_reg, b_next;
    logic [W-1:0] data_reg, data_next;
    logic [W-1:0] result_reg, result_next;
    logic         push_reg, push_next;
    logic         pop_reg, pop_next;
    logic         replace_reg, replace_next;
    logic         done_reg, done_next;
    logic         err_reg, err_next;

    logic         ready;
    logic         accept;
    logic         depth_ok;
    logic [W-1:0] prod;

    assign ready  = (state_reg == IDLE) & bus.st_vld & ~done_reg;
    assign accept = ready & bus.cmd_valid;
    assign prod   = bus.st_top * a_reg;

    always_comb begin
        case (bus.cmd_op)
            OP_PUSH, OP_DUP: depth_ok = (bus.st_size < DEPTH_L);
            OP_POP, OP_NEG:  depth_ok = (bus.st_size >= 10'd1);
            default:         depth_ok = (bus.st_size >= 10'd2);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            after_reg   <= IDLE;
            op_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            data_reg    <= '0;
            result_reg  <= '0;
            push_reg    <= 1'b0;
            pop_reg     <= 1'b0;
            replace_reg <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            after_reg   <= after_next;
            op_reg      <= op_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            data_reg    <= data_next;
            result_reg  <= result_next;
            push_reg    <= push_next;
            pop_reg     <= pop_next;
            replace_reg <= replace_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        after_next   = after_reg;
        op_next      = op_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        data_next    = data_reg;
        result_next  = result_reg;
        err_next     = err_reg;
        push_next    = 1'b0;
        pop_next     = 1'b0;
        replace_next = 1'b0;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    op_next = bus.cmd_op;
                    a_next  = bus.st_top;
                    if (!depth_ok) begin
                        state_next  = DONE;
                        done_next   = 1'b1;
                        err_next    = 1'b1;
                        result_next = bus.st_top;
                    end else begin
                        state_next = SETTLE;
                        after_next = DONE;
                        case (bus.cmd_op)
                            OP_PUSH: begin
                                push_next = 1'b1;
                                data_next = bus.cmd_num;
                            end
                            OP_DUP: begin
                                push_next = 1'b1;
                                data_next = bus.st_top;
                            end
                            OP_POP: pop_next = 1'b1;
                            OP_NEG: begin
                                replace_next = 1'b1;
                                data_next    = -bus.st_top;
                            end
                            OP_SWAP: begin
                                pop_next   = 1'b1;
                                after_next = WR;
                            end
                            default: begin
                                pop_next   = 1'b1;
                                after_next = OPER;
                            end
                        endcase
                    end
                end
            end

            // The stack may not have dropped st_vld yet on the strobe's own edge.
            SETTLE: state_next = WAITV;

            WAITV: begin
                if (bus.st_vld) begin
                    state_next = SETTLE;
                    after_next = DONE;
                    case (after_reg)
                        OPER: begin
                            b_next       = bus.st_top;
                            replace_next = 1'b1;
                            case (op_reg)
                                OP_ADD:  data_next = bus.st_top + a_reg;
                                OP_SUB:  data_next = bus.st_top - a_reg;
                                default: data_next = prod;
                            endcase
                        end
                        WR: begin
                            b_next       = bus.st_top;
                            replace_next = 1'b1;
                            data_next    = a_reg;
                            after_next   = WR2;
                        end
                        WR2: begin
                            push_next = 1'b1;
                            data_next = b_reg;
                        end
                        default: begin
                            state_next  = DONE;
                            done_next   = 1'b1;
                            err_next    = 1'b0;
                            result_next = bus.st_top;
                        end
                    endcase
                end
            end

            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.cmd_ready  = ready;
    assign bus.done       = done_reg;
    assign bus.err        = err_reg;
    assign bus.result     = result_reg;
    assign bus.st_push    = push_reg;
    assign bus.st_pop     = pop_reg;
    assign bus.st_replace = replace_reg;
    assign bus.st_data    = data_reg;
endmodule
